spi_slv: RTL and testbench
==========================

Name: spi_slv

Overview:
- SPI mode 0 (CPOL=0, CPHA=0) slave/responder, the far end of the team's SPI master.
- Oversamples SCLK, SS_N and MOSI in the clk domain through synchronizers, then shifts MOSI in on SCLK rising edges and drives MISO on SCLK falling edges.
- Exposes a host-side frame interface: transmit word and length are loaded at frame start; the received word and bit count are presented with a one-cycle valid pulse at frame end.

Parameters:
- SPI_MAXLEN, 32: maximum bits per frame; width of tx_data and rx_data.
- SYNC_STAGES, 2: flip-flop depth of the SCLK/SS_N/MOSI synchronizers; must be ≥2.

Ports:
- clk  input  1  system clock; all logic is synchronous to it.
- resetn_shift  input  1  reset, asynchronous, active-low.
- SCLK  input  1  SPI clock from the master.
- SS_N  input  1  slave select, active low.
- MOSI  input  1  serial data from the master.
- MISO  output  1  serial data to the master.
- tx_data  input  SPI_MAXLEN  word to transmit; first bit out is tx_data[tx_len-1].
- tx_len  input  $clog2(SPI_MAXLEN)+1  number of valid tx bits, 1..SPI_MAXLEN.
- tx_ready  output  1  high in IDLE; tx_data/tx_len are sampled at the next frame start.
- busy  output  1  high while a frame is active.
- rx_data  output  SPI_MAXLEN  received word, right-justified; the last bit received is at rx_data[0].
- rx_nbits  output  $clog2(SPI_MAXLEN)+1  number of SCLK rising edges seen in the last frame, saturating at SPI_MAXLEN.
- rx_valid  output  1  one-cycle pulse; rx_data, rx_nbits and rx_overrun are valid.
- rx_overrun  output  1  last frame had more than SPI_MAXLEN rising edges.

Behaviour:
- Reset: the asynchronous reset clears all state.
  - Outputs at reset: MISO=0, tx_ready=1, busy=0, rx_data=0, rx_nbits=0, rx_valid=0, rx_overrun=0.
  - Synchronizers reset to the idle bus values: SCLK=0, SS_N=1, MOSI=0.
- Synchronization: SCLK, SS_N and MOSI pass through identical SYNC_STAGES chains so they stay mutually aligned.
- Edge detection: a registered copy of each synchronized signal gives single-cycle sclk_rise, sclk_fall, ss_fall and ss_rise strobes.
- Timing requirement on the master: the SCLK half-period and the SS_N-fall-to-first-SCLK-rise time must each be ≥ SYNC_STAGES+3 clk cycles.
- State machine IDLE -> ACTIVE -> DONE -> IDLE.
  - IDLE: tx_ready=1.
    - On ss_fall, load tx_shift = tx_data << (SPI_MAXLEN - tx_len), drive MISO = tx_data[tx_len-1] in the same cycle, clear bit_cnt, rx_shift and the overrun flag, and go to ACTIVE.
    - tx_len=0 is treated as SPI_MAXLEN.
  - ACTIVE: busy=1, tx_ready=0.
    - sclk_rise: rx_shift <= {rx_shift[SPI_MAXLEN-2:0], MOSI_sync}. If bit_cnt < SPI_MAXLEN, bit_cnt++; otherwise set the overrun flag (the shift still occurs, keeping the last SPI_MAXLEN bits).
    - sclk_fall: tx_shift shifts left one position and MISO = new tx_shift MSB. After tx_len bits have been sent, MISO=0.
    - ss_rise: go to DONE. This applies even mid-frame or with zero clocks.
  - DONE: one cycle, then IDLE.
    - rx_valid=1.
    - rx_data <= rx_shift masked to the low bit_cnt bits; all bits are kept when bit_cnt=SPI_MAXLEN.
    - rx_nbits <= bit_cnt; rx_overrun <= overrun flag.
    - MISO <= 0.
    - rx_* outputs hold until the next DONE.
- Simultaneous events:
  - If ss_rise coincides with sclk_rise, apply the shift first and then end the frame (the bit is counted).
  - sclk_fall coinciding with ss_rise is ignored.
- SCLK edges while SS_N is high are ignored.
- A zero-clock frame produces rx_valid with rx_nbits=0 and rx_data=0.
- ss_fall during DONE is registered and taken on the IDLE cycle. The frame therefore starts one cycle later, which the master timing requirement covers.
- Reset asserted mid-frame aborts the frame with no rx_valid and returns all outputs to their reset values.

Optional Feature:
- Macro: SPI_SLV_MISO_OE_EN.
- When defined:
  - Adds output miso_oe (1 bit).
  - miso_oe=1 only in ACTIVE; it is 0 at reset, in IDLE and in DONE.
  - MISO holds its value but is only meaningful when miso_oe=1, so the top level can tristate a shared MISO line.
- When undefined: no miso_oe port, and MISO is always driven as described above.

Test Plan:
- Basic 8-bit frame, SPI_MAXLEN=32, SCLK half-period 10 clk, tx_data=0xA5, tx_len=8; master sends 0x3C.
  - MISO sequence on rising edges: 1,0,1,0,0,1,0,1.
  - rx_valid pulse with rx_data=0x0000003C, rx_nbits=8, rx_overrun=0.
- Full-width frame, tx_data=0xDEADBEEF, tx_len=32; master sends 0x12345678.
  - Master receives 0xDEADBEEF.
  - rx_data=0x12345678, rx_nbits=32.
- Overrun: 34 clocks with MOSI pattern 0x3_FFFF_FFFE.
  - rx_data=0xFFFFFFFE, rx_nbits=32, rx_overrun=1.
- Short frame: SS_N deasserted after 3 clocks, MOSI bits 1,1,0.
  - rx_data=0x6, rx_nbits=3; MISO=0 after DONE.
- Zero-clock frame: SS_N low for 20 clk with no SCLK.
  - rx_valid with rx_nbits=0, rx_data=0.
  - tx_ready returns to 1 two cycles after the synchronized SS_N rise.
- Reset mid-frame: assert resetn_shift=0 after 5 of 8 clocks.
  - No rx_valid; MISO=0, busy=0, tx_ready=1.
  - The next full frame 0x81 receives rx_data=0x81, rx_nbits=8.

Source files
------------

// File: rtl/spi_slv.sv
// SPI mode 0 responder: synchronizes SCLK/SS_N/MOSI into clk, shifts MOSI on SCLK rise, drives MISO on SCLK fall.
// Optional macro SPI_SLV_MISO_OE_EN adds a miso_oe output that is high only while a frame is active.
module spi_slv #(
  parameter int SPI_MAXLEN  = 32,
  parameter int SYNC_STAGES = 2,
  localparam int CW = $clog2(SPI_MAXLEN) + 1
) (
  input  logic                  clk,
  input  logic                  resetn_shift,
  input  logic                  SCLK,
  input  logic                  SS_N,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [SPI_MAXLEN-1:0] tx_data,
  input  logic [CW-1:0]         tx_len,
  output logic                  tx_ready,
  output logic                  busy,
  output logic [SPI_MAXLEN-1:0] rx_data,
  output logic [CW-1:0]         rx_nbits,
  output logic                  rx_valid,
  output logic                  rx_overrun
`ifdef SPI_SLV_MISO_OE_EN
  ,
  output logic                  miso_oe
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Host handshake: tx_data/tx_len must be stable while tx_ready=1; they are
  // captured on the frame-start cycle. rx_valid is a one-cycle strobe with no
  // back-pressure; rx_data/rx_nbits/rx_overrun hold until the next frame ends.

  logic [SYNC_STAGES-1:0] sclk_sr, ss_sr, mosi_sr;
  logic                   sclk_d, ss_d;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;

  logic [1:0]             state;
  logic [SPI_MAXLEN-1:0]  tx_shift, rx_shift;
  logic [CW-1:0]          bit_cnt;
  logic                   ovr_flag;
  logic                   ss_pend;

  logic [CW-1:0]          eff_len;
  logic [SPI_MAXLEN-1:0]  tx_load;
  logic [SPI_MAXLEN-1:0]  nxt_rx_shift;
  logic [CW-1:0]          nxt_bit_cnt;
  logic                   nxt_ovr;
  logic [SPI_MAXLEN-1:0]  rx_mask;

  // All three inputs share identical chains so their relative timing is preserved.
  always_ff @(posedge clk or negedge resetn_shift) begin
    if (!resetn_shift) begin
      sclk_sr <= '0;
      ss_sr   <= '1;
      mosi_sr <= '0;
      sclk_d  <= 1'b0;
      ss_d    <= 1'b1;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], SCLK};
      ss_sr   <= {ss_sr[SYNC_STAGES-2:0], SS_N};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], MOSI};
      sclk_d  <= sclk_sr[SYNC_STAGES-1];
      ss_d    <= ss_sr[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign ss_s      = ss_sr[SYNC_STAGES-1];
  assign mosi_s    = mosi_sr[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign ss_rise   = ss_s & ~ss_d;

  // Left-aligning the word means zeros follow the last valid bit, so MISO
  // falls to 0 on its own once tx_len bits have gone out.
  always_comb begin
    eff_len = tx_len;
    if (tx_len == '0 || tx_len > CW'(SPI_MAXLEN))
      eff_len = CW'(SPI_MAXLEN);
    tx_load = tx_data << (CW'(SPI_MAXLEN) - eff_len);
  end

  always_comb begin
    nxt_rx_shift = rx_shift;
    nxt_bit_cnt  = bit_cnt;
    nxt_ovr      = ovr_flag;
    if (sclk_rise) begin
      nxt_rx_shift = {rx_shift[SPI_MAXLEN-2:0], mosi_s};
      if (bit_cnt < CW'(SPI_MAXLEN))
        nxt_bit_cnt = bit_cnt + CW'(1);
      else
        nxt_ovr = 1'b1;
    end
    for (int i = 0; i < SPI_MAXLEN; i++)
      rx_mask[i] = (CW'(i) < nxt_bit_cnt);
  end

  always_ff @(posedge clk or negedge resetn_shift) begin
    if (!resetn_shift) begin
      state      <= ST_IDLE;
      tx_shift   <= '0;
      rx_shift   <= '0;
      bit_cnt    <= '0;
      ovr_flag   <= 1'b0;
      ss_pend    <= 1'b0;
      MISO       <= 1'b0;
      rx_data    <= '0;
      rx_nbits   <= '0;
      rx_overrun <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ss_fall || ss_pend) begin
            tx_shift <= tx_load;
            MISO     <= tx_load[SPI_MAXLEN-1];
            bit_cnt  <= '0;
            rx_shift <= '0;
            ovr_flag <= 1'b0;
            ss_pend  <= 1'b0;
            state    <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          rx_shift <= nxt_rx_shift;
          bit_cnt  <= nxt_bit_cnt;
          ovr_flag <= nxt_ovr;
          // Frame end wins over a coincident SCLK fall; a coincident rise is still counted.
          if (ss_rise) begin
            rx_data    <= nxt_rx_shift & rx_mask;
            rx_nbits   <= nxt_bit_cnt;
            rx_overrun <= nxt_ovr;
            MISO       <= 1'b0;
            state      <= ST_DONE;
          end else if (sclk_fall) begin
            tx_shift <= {tx_shift[SPI_MAXLEN-2:0], 1'b0};
            MISO     <= tx_shift[SPI_MAXLEN-2];
          end
        end
        ST_DONE: begin
          MISO  <= 1'b0;
          state <= ST_IDLE;
          if (ss_fall)
            ss_pend <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign tx_ready = (state == ST_IDLE);
  assign busy     = (state == ST_ACTIVE);
  assign rx_valid = (state == ST_DONE);

`ifdef SPI_SLV_MISO_OE_EN
  assign miso_oe = (state == ST_ACTIVE);
`endif

endmodule

// File: tb/tb_spi_slv.sv
// Bench for spi_slv: table of SPI frames driven by a mode-0 master model, rx results checked via an expected queue.
module tb_spi_slv;

  localparam int ML = 32;
  localparam int CW = $clog2(ML) + 1;
  localparam int HP = 10;

  logic          clk = 1'b0;
  logic          resetn_shift = 1'b0;
  logic          SCLK = 1'b0;
  logic          SS_N = 1'b1;
  logic          MOSI = 1'b0;
  logic          MISO;
  logic [ML-1:0] tx_data = '0;
  logic [CW-1:0] tx_len = '0;
  logic          tx_ready, busy, rx_valid, rx_overrun;
  logic [ML-1:0] rx_data;
  logic [CW-1:0] rx_nbits;
`ifdef SPI_SLV_MISO_OE_EN
  logic          miso_oe;
`endif

  int checks = 0;
  int errors = 0;

  // {overrun, nbits, data}
  logic [ML+CW:0] exp_q[$];

  typedef struct {
    logic [31:0] txd;
    logic [5:0]  txl;
    logic [63:0] mosi;
    int          nclk;
    logic [31:0] rxd;
    logic [5:0]  nbits;
    logic        ovr;
  } vec_t;

  vec_t vecs[5];

  spi_slv #(.SPI_MAXLEN(ML), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetn_shift(resetn_shift),
    .SCLK(SCLK), .SS_N(SS_N), .MOSI(MOSI), .MISO(MISO),
    .tx_data(tx_data), .tx_len(tx_len), .tx_ready(tx_ready), .busy(busy),
    .rx_data(rx_data), .rx_nbits(rx_nbits), .rx_valid(rx_valid), .rx_overrun(rx_overrun)
`ifdef SPI_SLV_MISO_OE_EN
    , .miso_oe(miso_oe)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for rx_valid, pops the scoreboard and compares all rx fields.
  task automatic check_rx(input string name);
    logic [ML+CW:0] e;
    int k;
    k = 0;
    while (!rx_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (!rx_valid) begin
      chk({name, " rx_valid timeout"}, 64'd0, 64'd1);
    end else if (exp_q.size() == 0) begin
      chk({name, " unexpected rx_valid"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk({name, " rx_data"}, 64'(rx_data), 64'(e[ML-1:0]));
      chk({name, " rx_nbits"}, 64'(rx_nbits), 64'(e[ML+CW-1:ML]));
      chk({name, " rx_overrun"}, 64'(rx_overrun), 64'(e[ML+CW]));
      @(negedge clk);
      chk({name, " rx_valid pulse width"}, 64'(rx_valid), 64'd0);
    end
  endtask

  // Mode-0 master. abort_at >= 0 applies reset before that bit instead of finishing.
  task automatic run_frame(input string name, input logic [31:0] txd, input logic [5:0] txl,
                           input logic [63:0] mosi, input int nclk, input logic [ML+CW:0] exp,
                           input int abort_at, output logic [63:0] mrx);
    int len;
    logic eb;
    int seen;
    len = (txl == 0) ? ML : int'(txl);
    mrx = '0;
    tx_data = txd;
    tx_len = txl;
    if (abort_at < 0) exp_q.push_back(exp);
    SS_N = 1'b0;
    MOSI = (nclk > 0) ? mosi[nclk-1] : 1'b0;
    wait_clk(HP);
    chk({name, " busy"}, 64'(busy), 64'd1);
    chk({name, " tx_ready low"}, 64'(tx_ready), 64'd0);
    for (int i = 0; i < nclk; i++) begin
      if (i == abort_at) begin
        resetn_shift = 1'b0;
        SCLK = 1'b0;
        SS_N = 1'b1;
        wait_clk(2);
        chk({name, " reset MISO"}, 64'(MISO), 64'd0);
        chk({name, " reset busy"}, 64'(busy), 64'd0);
        chk({name, " reset tx_ready"}, 64'(tx_ready), 64'd1);
        chk({name, " reset rx_valid"}, 64'(rx_valid), 64'd0);
        resetn_shift = 1'b1;
        seen = 0;
        for (int j = 0; j < 30; j++) begin
          @(negedge clk);
          if (rx_valid) seen++;
        end
        chk({name, " no rx_valid after abort"}, 64'(seen), 64'd0);
        return;
      end
      SCLK = 1'b1;
      eb = (i < len) ? txd[len-1-i] : 1'b0;
      chk($sformatf("%s MISO bit %0d", name, i), 64'(MISO), 64'(eb));
      mrx = {mrx[62:0], MISO};
      wait_clk(HP);
      SCLK = 1'b0;
      if (i + 1 < nclk) MOSI = mosi[nclk-2-i];
      wait_clk(HP);
    end
    SS_N = 1'b1;
    check_rx(name);
    wait_clk(2);
    chk({name, " MISO idle"}, 64'(MISO), 64'd0);
    chk({name, " tx_ready idle"}, 64'(tx_ready), 64'd1);
    wait_clk(5);
  endtask

  initial begin
    logic [63:0] mrx;
    vecs[0] = '{32'h000000A5, 6'd8,  64'h3C,          8,  32'h0000003C, 6'd8,  1'b0};
    vecs[1] = '{32'hDEADBEEF, 6'd32, 64'h12345678,    32, 32'h12345678, 6'd32, 1'b0};
    vecs[2] = '{32'h0F0F0F0F, 6'd0,  64'h3_FFFF_FFFE, 34, 32'hFFFFFFFE, 6'd32, 1'b1};
    vecs[3] = '{32'h000000C0, 6'd8,  64'h6,           3,  32'h00000006, 6'd3,  1'b0};
    vecs[4] = '{32'h00000001, 6'd1,  64'h16,          5,  32'h00000016, 6'd5,  1'b0};

    wait_clk(3);
    chk("reset MISO", 64'(MISO), 64'd0);
    chk("reset tx_ready", 64'(tx_ready), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset rx_data", 64'(rx_data), 64'd0);
    chk("reset rx_nbits", 64'(rx_nbits), 64'd0);
    chk("reset rx_valid", 64'(rx_valid), 64'd0);
    chk("reset rx_overrun", 64'(rx_overrun), 64'd0);
    resetn_shift = 1'b1;
    wait_clk(5);

    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].txd, vecs[i].txl, vecs[i].mosi, vecs[i].nclk,
                {vecs[i].ovr, vecs[i].nbits, vecs[i].rxd}, -1, mrx);
      if (vecs[i].nclk == 32)
        chk($sformatf("vec%0d master word", i), mrx[31:0], 64'(vecs[i].txd));
    end

    // Zero-clock frame with exact tx_ready return timing.
    tx_data = 32'h55;
    tx_len = 6'd8;
    SS_N = 1'b0;
    wait_clk(20);
    chk("zero busy", 64'(busy), 64'd1);
    exp_q.push_back('0);
    SS_N = 1'b1;
    wait_clk(3);
    chk("zero rx_valid", 64'(rx_valid), 64'd1);
    chk("zero tx_ready in done", 64'(tx_ready), 64'd0);
    check_rx("zero");
    chk("zero tx_ready back", 64'(tx_ready), 64'd1);
    wait_clk(5);

    run_frame("abort", 32'hA5, 6'd8, 64'h81, 8, '0, 5, mrx);
    wait_clk(5);
    run_frame("after_abort", 32'h3C, 6'd8, 64'h81, 8, {1'b0, 6'd8, 32'h81}, -1, mrx);

    chk("scoreboard empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule
